fetch_decode: RTL and testbench
===============================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 32'd1, meaning the PC increment per issued instruction (word-addressed memory).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  meaning the reset, which is synchronous and active-high.
REQ-005 SHALL have port Read_PC  output  32  meaning the instruction-memory fetch address.
REQ-006 SHALL have port Instruction  input  32  meaning the asynchronous memory read data for Read_PC.
REQ-007 SHALL have port dec_valid  output  1  meaning the decoded instruction is presented to control.
REQ-008 SHALL have port dec_ready  input  1  meaning control accepts the presented instruction.
REQ-009 SHALL have port opcode  output  3  meaning Instruction[31:29].
REQ-010 SHALL have port fonte_a  output  2  meaning Instruction[28:27], the source register.
REQ-011 SHALL have port dest  output  2  meaning Instruction[26:25], the destination register.
REQ-012 SHALL have port imediato  output  25  meaning Instruction[24:0], zero-extended by the consumer.
REQ-013 SHALL have port pc_out  output  32  meaning the address of the presented instruction.
REQ-014 SHALL have port halted  output  1  meaning the block is in HALT.
REQ-015 SHALL have port resume  input  1  meaning a single-cycle request to leave HALT.

Function
REQ-016 SHALL implement the states FETCH, ISSUE and HALT.
REQ-017 SHALL drive Read_PC combinationally from the internal pc register in every state.
REQ-018 In FETCH, SHALL latch Instruction into the instruction register (IR), set pc_out=pc and dec_valid=1, then move to ISSUE (1-cycle fetch latency).
REQ-019 In ISSUE, SHALL hold opcode, fonte_a, dest, imediato, pc_out and Read_PC stable while dec_valid=1 and dec_ready=0.
REQ-020 A handshake SHALL occur on a cycle where dec_valid=1 and dec_ready=1; it SHALL set pc<=pc+PC_STEP modulo 2^32 (32'hFFFF_FFFF+1 wraps to 0).
REQ-021 On a handshake with opcode!=3'b101, SHALL move to FETCH and set dec_valid=0.
REQ-022 On a handshake with opcode==3'b101 (halt), SHALL move to HALT, set dec_valid=0 and halted=1.
REQ-023 In HALT, SHALL keep pc frozen and ignore dec_ready; resume=1 SHALL move to FETCH and set halted=0 on the next cycle.
REQ-024 SHALL ignore resume outside HALT and dec_ready while dec_valid=0.
REQ-025 SHALL treat all other opcodes (000-100, 110, 111) identically; this block only decodes.

Reset
REQ-026 reset=1 SHALL override dec_ready and resume on the same edge; the next state SHALL be FETCH.
REQ-027 Reset values SHALL be pc=RESET_PC, Read_PC=RESET_PC, dec_valid=0, halted=0, and IR, opcode, fonte_a, dest, imediato and pc_out all zero.
REQ-028 A reset during ISSUE SHALL discard the presented instruction with no pc advance.

Configuration
REQ-029 With FD_PIPELINE_EN defined, a non-halt handshake in ISSUE SHALL drive Read_PC=pc+PC_STEP in that cycle, load the next IR on the same edge and stay in ISSUE with dec_valid=1, giving 1 instruction/cycle.
REQ-030 Without FD_PIPELINE_EN, every instruction SHALL pass through FETCH, giving at most 1 instruction per 2 cycles.

Structure
REQ-031 Package fd_pkg SHALL hold the opcode constants (OP_SOMA=000, OP_SUB=001, OP_DIV=010, OP_MUL=011, OP_MCLR=100, OP_HALT=101, OP_MRD=110, OP_MWR=111), the state encoding and the field bit positions.
REQ-032 Field extraction SHALL be a combinational sub-module named instr_decode, instantiated on the IR.

Verification
REQ-033 Reset with mem[0]=32'h0800_0005 -> one cycle after reset release: dec_valid=1, opcode=0, fonte_a=1, dest=0, imediato=5, pc_out=0.
REQ-034 dec_ready=0 for 3 cycles in ISSUE -> outputs and Read_PC=0 unchanged; dec_ready=1 -> next cycle Read_PC=1.
REQ-035 mem[1]=32'hA000_0000 issued and accepted -> halted=1, dec_valid=0, Read_PC=2 held for 5 cycles; resume pulse -> fetch at 2, halted=0.
REQ-036 RESET_PC=32'hFFFF_FFFF, accepted instruction -> Read_PC=0.
REQ-037 reset=1 and dec_ready=1 together in ISSUE at pc=3 -> dec_valid=0, pc=RESET_PC, no handshake counted.
REQ-038 With FD_PIPELINE_EN and dec_ready held at 1, four non-halt instructions -> handshakes on four consecutive cycles, pc_out=0,1,2,3.

Source files
------------

// File: rtl/fd_pkg.sv
// Shared definitions for the fetch/decode slice: opcode map, FSM encoding and
// instruction field positions.
package fd_pkg;

  localparam logic [2:0] OP_SOMA = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_MCLR = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;
  localparam logic [2:0] OP_MRD  = 3'b110;
  localparam logic [2:0] OP_MWR  = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_ISSUE = 2'b01,
    ST_HALT  = 2'b10
  } fd_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 29;
  localparam int FONTE_MSB  = 28;
  localparam int FONTE_LSB  = 27;
  localparam int DEST_MSB   = 26;
  localparam int DEST_LSB   = 25;
  localparam int IMM_MSB    = 24;
  localparam int IMM_LSB    = 0;

  function automatic logic is_halt(input logic [2:0] op);
    return (op == OP_HALT);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Pure field extraction from a 32-bit instruction word.
module instr_decode
  import fd_pkg::*;
(
  input  logic [31:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  fonte_a,
  output logic [1:0]  dest,
  output logic [24:0] imediato
);

  assign opcode   = ir[OPCODE_MSB:OPCODE_LSB];
  assign fonte_a  = ir[FONTE_MSB:FONTE_LSB];
  assign dest     = ir[DEST_MSB:DEST_LSB];
  assign imediato = ir[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_decode.sv
// Fetch/issue front end with a ready/valid handshake to control and a HALT state.
// Optional back-to-back issue when FD_PIPELINE_EN is defined.
module fetch_decode
  import fd_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Read_PC,
  input  logic [31:0] Instruction,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [2:0]  opcode,
  output logic [1:0]  fonte_a,
  output logic [1:0]  dest,
  output logic [24:0] imediato,
  output logic [31:0] pc_out,
  output logic        halted,
  input  logic        resume
);

  fd_state_e   state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] ir_r, ir_s;
  logic [31:0] pc_out_r, pc_out_s;
  logic        dec_valid_r, dec_valid_s;
  logic        halted_r, halted_s;
  logic [31:0] pc_inc_s;
  logic [31:0] fetch_pc_s;
  logic        handshake_s;

  assign pc_inc_s    = pc_r + PC_STEP;
  assign handshake_s = dec_valid_r & dec_ready;

  // Next-state, next-register and fetch-address logic.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    ir_s        = ir_r;
    pc_out_s    = pc_out_r;
    dec_valid_s = dec_valid_r;
    halted_s    = halted_r;
    fetch_pc_s  = pc_r;
    case (state_r)
      ST_FETCH: begin
        ir_s        = Instruction;
        pc_out_s    = pc_r;
        dec_valid_s = 1'b1;
        state_s     = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (handshake_s) begin
          pc_s = pc_inc_s;
          if (is_halt(opcode)) begin
            state_s     = ST_HALT;
            dec_valid_s = 1'b0;
            halted_s    = 1'b1;
          end else begin
`ifdef FD_PIPELINE_EN
            // Fetch the successor in the handshake cycle so control sees it next cycle.
            fetch_pc_s  = pc_inc_s;
            ir_s        = Instruction;
            pc_out_s    = pc_inc_s;
            state_s     = ST_ISSUE;
`else
            state_s     = ST_FETCH;
            dec_valid_s = 1'b0;
`endif
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_s  = ST_FETCH;
          halted_s = 1'b0;
        end else begin
          state_s  = ST_HALT;
        end
      end
      default: begin
        state_s     = ST_FETCH;
        dec_valid_s = 1'b0;
        halted_s    = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset wins over any handshake or resume.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_FETCH;
      pc_r        <= RESET_PC;
      ir_r        <= 32'h0000_0000;
      pc_out_r    <= 32'h0000_0000;
      dec_valid_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      ir_r        <= ir_s;
      pc_out_r    <= pc_out_s;
      dec_valid_r <= dec_valid_s;
      halted_r    <= halted_s;
    end
  end

  instr_decode u_decode (
    .ir       (ir_r),
    .opcode   (opcode),
    .fonte_a  (fonte_a),
    .dest     (dest),
    .imediato (imediato)
  );

  assign Read_PC   = fetch_pc_s;
  assign pc_out    = pc_out_r;
  assign dec_valid = dec_valid_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: every accepted instruction is compared
// against fields the bench derives from its own memory image.
module tb_fetch_decode;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  op;
    logic [1:0]  fa;
    logic [1:0]  dst;
    logic [24:0] imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, dec_ready, resume, dec_ready2;
  logic [31:0] Read_PC, Instruction, pc_out;
  logic        dec_valid, halted;
  logic [2:0]  opcode;
  logic [1:0]  fonte_a, dest;
  logic [24:0] imediato;
  logic [31:0] read_pc2, instr2, pc_out2;
  logic        dec_valid2, halted2;
  logic [2:0]  opcode2;
  logic [1:0]  fonte_a2, dest2;
  logic [24:0] imediato2;

  logic [31:0] mem [16];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          hs_cnt = 0;

  always #5 clk = ~clk;

  assign Instruction = mem[Read_PC[3:0]];
  assign instr2      = 32'h0000_0000;

  fetch_decode dut (
    .clk(clk), .reset(reset), .Read_PC(Read_PC), .Instruction(Instruction),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .opcode(opcode),
    .fonte_a(fonte_a), .dest(dest), .imediato(imediato), .pc_out(pc_out),
    .halted(halted), .resume(resume)
  );

  fetch_decode #(.RESET_PC(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .reset(reset), .Read_PC(read_pc2), .Instruction(instr2),
    .dec_valid(dec_valid2), .dec_ready(dec_ready2), .opcode(opcode2),
    .fonte_a(fonte_a2), .dest(dest2), .imediato(imediato2), .pc_out(pc_out2),
    .halted(halted2), .resume(1'b0)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic push_exp(input int a);
    exp_t        e;
    logic [31:0] w;
    w     = mem[a];
    e.pc  = 32'(a);
    e.op  = w[31:29];
    e.fa  = w[28:27];
    e.dst = w[26:25];
    e.imm = w[24:0];
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a handshake is pending on the next edge when valid&ready are seen here.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && dec_valid && dec_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_pc_out", pc_out, e.pc);
        check_eq("sb_opcode", {29'd0, opcode}, {29'd0, e.op});
        check_eq("sb_fonte_a", {30'd0, fonte_a}, {30'd0, e.fa});
        check_eq("sb_dest", {30'd0, dest}, {30'd0, e.dst});
        check_eq("sb_imediato", {7'd0, imediato}, {7'd0, e.imm});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0000;
    mem[0] = 32'h0800_0005;
    mem[1] = 32'hA000_0000;
    mem[2] = 32'h2A00_0123;
    mem[3] = 32'hE7FF_FFFF;
    mem[4] = 32'h4000_0007;
    mem[5] = 32'h6000_0008;
    mem[6] = 32'h8000_0009;
    reset = 1'b1; dec_ready = 1'b0; resume = 1'b0; dec_ready2 = 1'b0;
    repeat (2) step();

    @(negedge clk);
    check_eq("rst_valid", {31'd0, dec_valid}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_read_pc", Read_PC, 32'd0);
    check_eq("rst_opcode", {29'd0, opcode}, 32'd0);
    check_eq("rst_imediato", {7'd0, imediato}, 32'd0);
    check_eq("rst_pc_out", pc_out, 32'd0);
    check_eq("rst_read_pc_wrap", read_pc2, 32'hFFFF_FFFF);

    step(); reset = 1'b0;
    push_exp(0); push_exp(1);
    step();
    @(negedge clk);
    check_eq("first_valid", {31'd0, dec_valid}, 32'd1);
    check_eq("first_opcode", {29'd0, opcode}, 32'd0);
    check_eq("first_fonte_a", {30'd0, fonte_a}, 32'd1);
    check_eq("first_dest", {30'd0, dest}, 32'd0);
    check_eq("first_imediato", {7'd0, imediato}, 32'd5);
    check_eq("first_pc_out", pc_out, 32'd0);

    step(); dec_ready2 = 1'b1;
    step(); dec_ready2 = 1'b0;
    @(negedge clk);
    check_eq("wrap_read_pc", read_pc2, 32'd0);

    repeat (3) begin
      step();
      @(negedge clk);
      check_eq("hold_read_pc", Read_PC, 32'd0);
      check_eq("hold_imediato", {7'd0, imediato}, 32'd5);
      check_eq("hold_valid", {31'd0, dec_valid}, 32'd1);
      check_eq("hold_pc_out", pc_out, 32'd0);
    end

    step(); dec_ready = 1'b1;
    step();
    @(negedge clk);
    check_eq("adv_read_pc", Read_PC, 32'd1);

    cyc = 0;
    while (!halted && cyc < 8) begin step(); cyc++; end
    check_eq("halt_seen", {31'd0, halted}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      check_eq("halt_flag", {31'd0, halted}, 32'd1);
      check_eq("halt_valid", {31'd0, dec_valid}, 32'd0);
      check_eq("halt_read_pc", Read_PC, 32'd2);
    end

    step(); dec_ready = 1'b0; resume = 1'b1;
    step(); resume = 1'b0;
    @(negedge clk);
    check_eq("resume_halted", {31'd0, halted}, 32'd0);
    check_eq("resume_read_pc", Read_PC, 32'd2);
    check_eq("resume_valid", {31'd0, dec_valid}, 32'd0);
    for (int a = 2; a < 6; a++) push_exp(a);
    step();
    @(negedge clk);
    check_eq("refetch_valid", {31'd0, dec_valid}, 32'd1);
    check_eq("refetch_pc_out", pc_out, 32'd2);

    step(); resume = 1'b1;
    step(); resume = 1'b0;
    @(negedge clk);
    check_eq("ign_resume_valid", {31'd0, dec_valid}, 32'd1);
    check_eq("ign_resume_pc_out", pc_out, 32'd2);

    step(); dec_ready = 1'b1;
    base = hs_cnt; cyc = 0;
    while (hs_cnt < base + 4 && cyc < 16) begin step(); cyc++; end
    dec_ready = 1'b0;
`ifdef FD_PIPELINE_EN
    check_eq("throughput_cycles", 32'(cyc), 32'd4);
`else
    check_eq("throughput_cycles", 32'(cyc), 32'd7);
`endif

    mem[1] = 32'hC000_0001;
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    push_exp(0); push_exp(1); push_exp(2);
    dec_ready = 1'b1;
    base = hs_cnt; cyc = 0;
    while (hs_cnt < base + 3 && cyc < 16) begin step(); cyc++; end
    dec_ready = 1'b0;
    cyc = 0;
    while (!dec_valid && cyc < 4) begin step(); cyc++; end
    check_eq("pre_rst_pc_out", pc_out, 32'd3);
    check_eq("pre_rst_read_pc", Read_PC, 32'd3);
    reset = 1'b1; dec_ready = 1'b1;
    step(); reset = 1'b0; dec_ready = 1'b0;
    @(negedge clk);
    check_eq("rr_valid", {31'd0, dec_valid}, 32'd0);
    check_eq("rr_read_pc", Read_PC, 32'd0);
    check_eq("rr_pc_out", pc_out, 32'd0);
    check_eq("rr_handshakes", 32'(hs_cnt), 32'(base + 3));
    push_exp(0);
    step();
    @(negedge clk);
    check_eq("rr_refetch_valid", {31'd0, dec_valid}, 32'd1);
    step(); dec_ready = 1'b1;
    step(); dec_ready = 1'b0;
    @(negedge clk);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
